// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready word RAM responder with LATENCY wait states and fault checking
module data_mem_responder #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE       = 32'h8000_0000,
   parameter int          LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_wen,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'd4 << DEPTH_LOG2);
   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d, wstrb_q, wstrb_d;
   logic [31:0]           addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic                  wen_q, wen_d, valid_q, valid_d, err_q, err_d;
   logic                  accept, commit, done, fault, mem_we;
   logic [DEPTH_LOG2-1:0] idx;
   logic [31:0]           mem [2**DEPTH_LOG2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         wen_q   <= 1'b0;
         wdata_q <= 32'd0;
         wstrb_q <= 4'd0;
         valid_q <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Counter reaching zero in WAIT marks the commit edge, giving LATENCY+1 edges from accept to response
   always_comb begin
      state_d = accept ? WAIT : commit ? RESP : done ? IDLE : state_q;
      cnt_d   = accept ? 4'(LATENCY) : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
      addr_d  = accept ? req_addr : addr_q;
      wen_d   = accept ? req_wen : wen_q;
      wdata_d = accept ? req_wdata : wdata_q;
      wstrb_d = accept ? req_wstrb : wstrb_q;
      valid_d = commit ? 1'b1 : done ? 1'b0 : valid_q;
      err_d   = commit ? fault : done ? 1'b0 : err_q;
      rdata_d = commit ? ((wen_q || fault) ? 32'd0 : mem[idx]) : done ? 32'd0 : rdata_q;
   end

   always_comb begin
      req_ready = state_q == IDLE;
      accept    = req_valid && req_ready;
      commit    = state_q == WAIT && cnt_q == 4'd0;
      done      = state_q == RESP && rsp_ready;
      fault     = addr_q[1:0] != 2'b00 || addr_q < BASE || {1'b0, addr_q} >= LIMIT;
      idx       = DEPTH_LOG2'((addr_q - BASE) >> 2);
      mem_we    = commit && wen_q && !fault;
      rsp_valid = valid_q;
      rsp_rdata = rdata_q;
      rsp_err   = err_q;
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         for (int i = 0; i < 4; i++)
            if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed table, hand-written corner sequences and randomized model checks
module tb_data_mem_responder;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 1024;

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_wen = 1'b0, rsp_ready = 1'b0;
   logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
   logic [3:0]  req_wstrb = 4'd0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        z_req_valid = 1'b0, z_req_wen = 1'b0, z_rsp_ready = 1'b0;
   logic [31:0] z_req_addr = 32'd0, z_req_wdata = 32'd0;
   logic [3:0]  z_req_wstrb = 4'd0;
   logic        z_req_ready, z_rsp_valid, z_rsp_err;
   logic [31:0] z_rsp_rdata;
   int          tests = 0, fails = 0;
   logic [31:0] model [int];

   data_mem_responder #(.DEPTH_LOG2(10), .BASE(BASE), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

   data_mem_responder #(.DEPTH_LOG2(10), .BASE(BASE), .LATENCY(0)) dut_z (
      .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
      .req_wen(z_req_wen), .req_wdata(z_req_wdata), .req_wstrb(z_req_wstrb), .rsp_valid(z_rsp_valid),
      .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // lat counts clock edges after the accept edge until rsp_valid is first seen
   task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic er, output int lat);
      @(negedge clk);
      check("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_wen = w; req_addr = a; req_wdata = d; req_wstrb = s; rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("rsp_timeout", rsp_valid, 1);
      rd = rsp_rdata;
      er = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_valid_after_hs", rsp_valid, 0);
   endtask

   function automatic logic is_fault(input logic [31:0] a);
      return a[1:0] != 2'b00 || a < BASE || {1'b0, a} >= {1'b0, BASE} + 33'(4 * DEPTH);
   endfunction

   initial begin
      vec_t        vecs [$];
      logic [31:0] rd, a, d, held, exp_rd;
      logic [3:0]  s;
      logic        er, w;
      int          lat, i;
      vecs = '{
         '{1'b1, 32'h8000_0000, 32'h1122_3344, 4'hF, 32'h0, 1'b0},
         '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0},
         '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0},
         '{1'b1, 32'h8000_0010, 32'h0000_00AA, 4'h1, 32'h0, 1'b0},
         '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0},
         '{1'b1, 32'h8000_0002, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1},
         '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1},
         '{1'b0, 32'h8000_1000, 32'h0,         4'h0, 32'h0, 1'b1},
         '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1},
         '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h1122_3344, 1'b0},
         '{1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0},
         '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0},
         '{1'b1, 32'h8000_0010, 32'h1234_5678, 4'h0, 32'h0, 1'b0},
         '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0},
         '{1'b1, 32'h8000_0010, 32'hABCD_0000, 4'hC, 32'h0, 1'b0},
         '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hABCD_BEAA, 1'b0}
      };
      #1;
      check("reset_req_ready", req_ready, 1);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_err", rsp_err, 0);
      check("reset_rsp_rdata", rsp_rdata, 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[k]) begin
         txn(vecs[k].wen, vecs[k].addr, vecs[k].wdata, vecs[k].strb, rd, er, lat);
         check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
         check($sformatf("vec%0d_err", k), er, vecs[k].exp_err);
         check($sformatf("vec%0d_latency", k), lat, 3);
      end

      // Backpressure: response held while rsp_ready low; request presented meanwhile must be ignored
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      i = 0;
      while (!rsp_valid && i < 40) begin
         @(negedge clk);
         i++;
      end
      held = rsp_rdata;
      check("bp_rdata", held, 32'hABCD_BEAA);
      for (int c = 0; c < 5; c++) begin
         if (c == 1) begin
            req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0010; req_wdata = 32'h0; req_wstrb = 4'hF;
         end
         if (c == 3) req_valid = 1'b0;
         @(negedge clk);
         check("bp_valid_held", rsp_valid, 1);
         check("bp_rdata_held", rsp_rdata, held);
         check("bp_req_ready_low", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("bp_valid_drop", rsp_valid, 0);
      check("bp_req_ready_back", req_ready, 1);
      check("bp_rdata_clear", rsp_rdata, 0);
      txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
      check("bp_ignored_write", rd, 32'hABCD_BEAA);

      // Reset during WAIT drops the pending write
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0000; req_wdata = 32'h5555_5555; req_wstrb = 4'hF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("wait_req_ready_low", req_ready, 0);
      rst = 1'b1;
      #1;
      check("wait_rst_req_ready", req_ready, 1);
      check("wait_rst_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
      check("wait_rst_old_data", rd, 32'h1122_3344);

      // Reset during RESP clears the pending error response asynchronously
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0002;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      i = 0;
      while (!rsp_valid && i < 40) begin
         @(negedge clk);
         i++;
      end
      check("resp_err_before_rst", rsp_err, 1);
      #2 rst = 1'b1;
      #1;
      check("resp_rst_valid", rsp_valid, 0);
      check("resp_rst_err", rsp_err, 0);
      check("resp_rst_rdata", rsp_rdata, 0);
      @(negedge clk);
      rst = 1'b0;

      // Zero-latency instance: response visible after the first edge following accept
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         z_req_valid = 1'b1; z_req_wen = (t == 0); z_req_addr = 32'h8000_0004;
         z_req_wdata = 32'h0A0B_0C0D; z_req_wstrb = 4'hF;
         @(posedge clk);
         @(negedge clk);
         z_req_valid = 1'b0;
         lat = 0;
         while (!z_rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
         end
         check("lat0_latency", lat, 1);
         check("lat0_rdata", z_rsp_rdata, t == 0 ? 32'h0 : 32'h0A0B_0C0D);
         check("lat0_err", z_rsp_err, 0);
         z_rsp_ready = 1'b1;
         @(negedge clk);
         z_rsp_ready = 1'b0;
         check("lat0_valid_drop", z_rsp_valid, 0);
      end

      // Randomized traffic over 16 words at both ends of the RAM plus faulting addresses
      for (int k = 0; k < 16; k++) begin
         a = BASE + 32'(4 * (k < 8 ? k : 1008 + k));
         d = $urandom;
         model[(k < 8 ? k : 1008 + k)] = d;
         txn(1'b1, a, d, 4'hF, rd, er, lat);
         check("init_err", er, 0);
      end
      for (int n = 0; n < 200; n++) begin
         i = $urandom_range(0, 15);
         a = BASE + 32'(4 * (i < 8 ? i : 1008 + i));
         case ($urandom_range(0, 7))
            0: a[1:0] = 2'($urandom_range(1, 3));
            1: a = $urandom_range(0, 1) ? BASE - 32'(4 * $urandom_range(1, 4))
                                        : BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
            default: ;
         endcase
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         exp_rd = 32'd0;
         if (!is_fault(a)) begin
            i = int'((a - BASE) >> 2);
            if (w) begin
               for (int b = 0; b < 4; b++)
                  if (s[b]) model[i][8*b +: 8] = d[8*b +: 8];
            end else exp_rd = model[i];
         end
         txn(w, a, d, s, rd, er, lat);
         check($sformatf("rand%0d_rdata", n), rd, exp_rd);
         check($sformatf("rand%0d_err", n), er, is_fault(a));
         check($sformatf("rand%0d_latency", n), lat, 3);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
